// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : UART transmit sequencer. It takes characters from the TX FIFO,
//            generates baud and oversample timing, and drives the serial pin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_sched #(
    parameter int DIV_WIDTH = 16,
    parameter int OS_NORMAL = 16,
    parameter int OS_ALT    = 13
) (
    input  logic                 apb_clk_in,
    input  logic                 apb_rst_in,
    input  logic [DIV_WIDTH-1:0] dlr_in,
    input  logic                 osm_in,
    input  logic [1:0]           wls_in,
    input  logic                 stb_in,
    input  logic                 pen_in,
    input  logic                 eps_in,
    input  logic                 sp_in,
    input  logic                 bc_in,
    input  logic                 tx_en_in,
    input  logic                 tx_valid_in,
    input  logic [7:0]           tx_data_in,
    output logic                 tx_ready_out,
    output logic                 txd_out,
    output logic                 temt_out,
    output logic                 tx_done_out,
    output logic                 baud_tick_out
);

    localparam int c_os_w = 8;
    localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);
    localparam logic [c_os_w-1:0]    c_os_one   = c_os_w'(1);
    localparam logic [c_os_w-1:0]    c_os_norm  = c_os_w'(OS_NORMAL);
    localparam logic [c_os_w-1:0]    c_os_alt   = c_os_w'(OS_ALT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t               state_q,   state_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] dlr_q,     dlr_d;
    logic [c_os_w-1:0]    os_cnt_q,  os_cnt_d;
    logic [c_os_w-1:0]    os_q,      os_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q,   shift_d;
    logic [1:0]           wls_q,     wls_d;
    logic                 stb_q,     stb_d;
    logic                 pen_q,     pen_d;
    logic                 par_q,     par_d;
    logic                 txd_q,     txd_d;
    logic                 done_q,    done_d;

    logic [7:0]           w_mask;
    logic [7:0]           w_masked;
    logic                 w_par;
    logic                 w_tick;
    logic                 w_bit_end;
    logic [c_os_w-1:0]    w_os_limit;
    logic [2:0]           w_last_data;
    logic                 w_fsm_txd;

    assign w_mask      = 8'hFF >> (2'd3 - wls_in);
    assign w_masked    = tx_data_in & w_mask;
    assign w_par       = sp_in ? ~eps_in : (eps_in ? ^w_masked : ~^w_masked);

    // A zero divisor never produces a tick, which freezes the frame in place.
    assign w_tick      = (state_q != S_IDLE) && (dlr_q != '0) && (div_cnt_q == dlr_q - c_div_one);
    // The second stop bit of a 5-bit character is a half bit (1.5 stop bits).
    assign w_os_limit  = (state_q == S_STOP2 && wls_q == 2'd0) ? (os_q >> 1) : os_q;
    assign w_bit_end   = w_tick && (os_cnt_q == w_os_limit - c_os_one);
    assign w_last_data = 3'd4 + {1'b0, wls_q};

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        dlr_d     = dlr_q;
        os_cnt_d  = os_cnt_q;
        os_d      = os_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wls_d     = wls_q;
        stb_d     = stb_q;
        pen_d     = pen_q;
        par_d     = par_q;
        done_d    = 1'b0;
        w_fsm_txd = 1'b1;

        if (!tx_en_in) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            if (tx_valid_in) begin
                state_d   = S_START;
                div_cnt_d = '0;
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                shift_d   = w_masked;
                dlr_d     = dlr_in;
                os_d      = osm_in ? c_os_alt : c_os_norm;
                wls_d     = wls_in;
                stb_d     = stb_in;
                pen_d     = pen_in;
                par_d     = w_par;
            end
        end else begin
            if (dlr_q != '0) begin
                div_cnt_d = w_tick ? '0 : div_cnt_q + c_div_one;
            end
            if (w_tick) begin
                os_cnt_d = w_bit_end ? '0 : os_cnt_q + c_os_one;
            end
            if (w_bit_end) begin
                case (state_q)
                    S_START: state_d = S_DATA;
                    S_DATA: begin
                        if (bit_cnt_q == w_last_data) begin
                            state_d = pen_q ? S_PARITY : S_STOP1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = shift_q >> 1;
                        end
                    end
                    S_PARITY: state_d = S_STOP1;
                    S_STOP1: begin
                        if (stb_q) begin
                            state_d = S_STOP2;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    S_STOP2: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // The pin value follows the state being entered, so the register lines up with it.
        case (state_d)
            S_START:  w_fsm_txd = 1'b0;
            S_DATA:   w_fsm_txd = shift_d[0];
            S_PARITY: w_fsm_txd = par_d;
            default:  w_fsm_txd = 1'b1;
        endcase
        txd_d = bc_in ? 1'b0 : w_fsm_txd;
    end

    always_ff @(posedge apb_clk_in) begin
        if (apb_rst_in) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            dlr_q     <= '0;
            os_cnt_q  <= '0;
            os_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wls_q     <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            dlr_q     <= dlr_d;
            os_cnt_q  <= os_cnt_d;
            os_q      <= os_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wls_q     <= wls_d;
            stb_q     <= stb_d;
            pen_q     <= pen_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    assign tx_ready_out  = (state_q == S_IDLE) && tx_en_in && !apb_rst_in;
    assign txd_out       = txd_q;
    assign temt_out      = (state_q == S_IDLE);
    assign tx_done_out   = done_q;
    assign baud_tick_out = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dlr;
    logic        osm, stb, pen, eps, sp, bc, tx_en, tx_valid;
    logic [1:0]  wls;
    logic [7:0]  tx_data;
    logic        tx_ready, txd, temt, tx_done, baud_tick;

    uart_tx_sched #(.DIV_WIDTH(16), .OS_NORMAL(16), .OS_ALT(13)) dut (
        .apb_clk_in    (clk),
        .apb_rst_in    (rst),
        .dlr_in        (dlr),
        .osm_in        (osm),
        .wls_in        (wls),
        .stb_in        (stb),
        .pen_in        (pen),
        .eps_in        (eps),
        .sp_in         (sp),
        .bc_in         (bc),
        .tx_en_in      (tx_en),
        .tx_valid_in   (tx_valid),
        .tx_data_in    (tx_data),
        .tx_ready_out  (tx_ready),
        .txd_out       (txd),
        .temt_out      (temt),
        .tx_done_out   (tx_done),
        .baud_tick_out (baud_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int       cfg_dlr;
    bit       cfg_osm, cfg_stb, cfg_pen, cfg_eps, cfg_sp;
    bit [1:0] cfg_wls;

    bit exp_wave[$];
    bit cap[$];
    int last_wait;
    int last_len;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected pin level for every clock after the accept edge, built bit by bit.
    task automatic build_wave(input logic [7:0] d);
        int os, bitclk, nd, ones;
        bit par;
        exp_wave.delete();
        os     = cfg_osm ? 13 : 16;
        bitclk = os * cfg_dlr;
        nd     = 5 + int'(cfg_wls);
        ones   = 0;
        repeat (bitclk) exp_wave.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            repeat (bitclk) exp_wave.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (cfg_pen) begin
            if (cfg_sp) par = !cfg_eps;
            else        par = cfg_eps ? (ones % 2 == 1) : (ones % 2 == 0);
            repeat (bitclk) exp_wave.push_back(par);
        end
        repeat (bitclk) exp_wave.push_back(1'b1);
        if (cfg_stb) repeat (((cfg_wls == 0) ? os / 2 : os) * cfg_dlr) exp_wave.push_back(1'b1);
    endtask

    task automatic apply_cfg();
        dlr = 16'(cfg_dlr);
        osm = cfg_osm; wls = cfg_wls; stb = cfg_stb;
        pen = cfg_pen; eps = cfg_eps; sp  = cfg_sp;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit keep_valid, input int abort_at,
                              input int bc_start, input int bc_len, input string tag);
        int L, waited, errs, ticks, done_at;
        bit bc_prev, exp_txd;
        build_wave(d);
        L = exp_wave.size();
        cap.delete();
        apply_cfg();
        tx_data  = d;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        last_wait = waited;
        if (!tx_ready) begin
            check_eq({tag, "_ready_timeout"}, tx_ready, 1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (!keep_valid) tx_valid = 1'b0;
        // Pin changes during the frame must be ignored until the next accept.
        dlr = 16'($urandom); osm = 1'($urandom); wls = 2'($urandom); stb = 1'($urandom);
        pen = 1'($urandom);  eps = 1'($urandom); sp  = 1'($urandom); tx_data = 8'($urandom);
        errs = 0; ticks = 0; done_at = -1; bc_prev = 1'b0;
        for (int t = 0; t <= L; t++) begin
            if (abort_at >= 0 && t == abort_at + 1) begin
                check_eq({tag, "_abort_txd"}, txd, 1);
                check_eq({tag, "_abort_temt"}, temt, 1);
                repeat (3) begin
                    if (tx_done) errs++;
                    @(posedge clk); #1;
                end
                check_eq({tag, "_abort_errs"}, errs, 0);
                tx_en = 1'b1;
                return;
            end
            cap.push_back(txd);
            exp_txd = bc_prev ? 1'b0 : ((t < L) ? exp_wave[t] : 1'b1);
            if (txd !== exp_txd) errs++;
            if (temt !== (t == L)) errs++;
            if (tx_done && done_at < 0) done_at = t;
            if (t < L && tx_done) errs++;
            if (t < L && baud_tick) ticks++;
            if (t < L) begin
                bc      = (t >= bc_start && t < bc_start + bc_len);
                bc_prev = bc;
                if (t == abort_at) tx_en = 1'b0;
                @(posedge clk); #1;
            end
        end
        bc = 1'b0;
        last_len = done_at;
        check_eq({tag, "_wave_errs"}, errs, 0);
        check_eq({tag, "_done_at"}, done_at, L);
        check_eq({tag, "_ticks"}, ticks, L / cfg_dlr);
    endtask

    task automatic set_cfg(input int d, input bit o, input bit [1:0] w, input bit s,
                           input bit p, input bit e, input bit stk);
        cfg_dlr = d; cfg_osm = o; cfg_wls = w; cfg_stb = s;
        cfg_pen = p; cfg_eps = e; cfg_sp = stk;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        rst = 1'b1; tx_en = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; bc = 1'b0;
        set_cfg(1, 0, 3, 0, 0, 0, 0);
        apply_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", tx_ready, 0);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_temt", temt, 1);
        check_eq("rst_done", tx_done, 0);
        check_eq("rst_tick", baud_tick, 0);
        rst = 1'b0;
        #1;
        check_eq("idle_ready", tx_ready, 1);

        // 8N1 at dlr=1: alternating pattern, 160 clocks
        set_cfg(1, 0, 3, 0, 0, 0, 0);
        send_frame(8'h55, 0, -1, -1, 0, "f55");
        errs = 0;
        for (int k = 0; k < 10; k++) if (cap[k * 16 + 8] != (k % 2)) errs++;
        check_eq("f55_pattern", errs, 0);
        check_eq("f55_len", last_len, 160);

        // Parity variants on 5-bit 0x1F; parity bit occupies clocks 96..111
        set_cfg(1, 0, 0, 0, 1, 0, 0);
        send_frame(8'h1F, 0, -1, -1, 0, "par_odd");
        check_eq("par_odd_bit", cap[104], 0);
        check_eq("par_odd_len", last_len, 128);
        set_cfg(1, 0, 0, 0, 1, 1, 0);
        send_frame(8'h1F, 0, -1, -1, 0, "par_even");
        check_eq("par_even_bit", cap[104], 1);
        set_cfg(1, 0, 0, 0, 1, 1, 1);
        send_frame(8'h1F, 0, -1, -1, 0, "par_stick");
        check_eq("par_stick_bit", cap[104], 0);

        // 1.5 stop bits, then 13x oversampling with 2 stop bits
        set_cfg(2, 0, 0, 1, 0, 0, 0);
        send_frame(8'h0A, 0, -1, -1, 0, "stop15");
        check_eq("stop15_len", last_len, 7 * 32 + 48 - 32);
        set_cfg(3, 1, 3, 1, 0, 0, 0);
        send_frame(8'hC3, 0, -1, -1, 0, "os13");
        check_eq("os13_len", last_len, 11 * 39);

        // Back-to-back with valid held high
        set_cfg(1, 0, 3, 0, 0, 0, 0);
        send_frame(8'h3C, 1, -1, -1, 0, "b2b_a");
        send_frame(8'h96, 0, -1, -1, 0, "b2b_b");
        check_eq("b2b_gap", last_wait, 0);

        // Abort during DATA, then recover
        send_frame(8'($urandom), 0, 53, -1, 0, "abort");
        send_frame(8'hA5, 0, -1, -1, 0, "after_abort");
        check_eq("after_abort_len", last_len, 160);

        // Break pulse of 50 clocks inside STOP1 (clocks 576..639)
        set_cfg(4, 0, 3, 0, 0, 0, 0);
        send_frame(8'($urandom), 0, -1, 580, 50, "brk");
        check_eq("brk_len", last_len, 640);
        errs = 0;
        for (int s = 581; s <= 630; s++) if (cap[s] != 1'b0) errs++;
        check_eq("brk_low", errs, 0);
        check_eq("brk_release", cap[631], 1);

        // Zero divisor stalls the frame until the transmitter is disabled
        set_cfg(0, 0, 3, 0, 0, 0, 0);
        apply_cfg();
        tx_data = 8'h33; tx_valid = 1'b1;
        errs = 0;
        while (!tx_ready && errs < 100) begin
            @(posedge clk); #1;
            errs++;
        end
        check_eq("dlr0_ready", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        errs = 0;
        repeat (300) begin
            if (txd !== 1'b0 || temt !== 1'b0 || tx_done || baud_tick) errs++;
            @(posedge clk); #1;
        end
        check_eq("dlr0_hold", errs, 0);
        tx_en = 1'b0;
        @(posedge clk); #1;
        check_eq("dlr0_recover_txd", txd, 1);
        check_eq("dlr0_recover_temt", temt, 1);
        tx_en = 1'b1;

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            set_cfg($urandom_range(1, 3), 1'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
            send_frame(8'($urandom), 1'($urandom), -1, -1, 0, "rnd");
        end
        tx_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit-side sequencer for the UART block.
- Pulls characters from the TX FIFO over a valid/ready handshake.
- Generates the baud/oversample timing from the divisor and oversample-mode register fields.
- Serialises each character as start, data (LSB first), optional parity, then stop bit(s) on txd_out.
- Sits between the register/FIFO block and the pad, and drives the TEMT status and transmit-complete interrupt source.

Parameters:
DIV_WIDTH, 16, width of divisor input dlr_in
OS_NORMAL, 16, oversample factor when osm_in=0
OS_ALT, 13, oversample factor when osm_in=1

Ports:
apb_clk_in  input  1  single clock for the whole block
apb_rst_in  input  1  synchronous active-high reset
dlr_in  input  DIV_WIDTH  baud divisor: clocks per sample tick
osm_in  input  1  oversample mode: 0 selects OS_NORMAL, 1 selects OS_ALT
wls_in  input  2  word length select; data bits = 5 + wls_in
stb_in  input  1  stop bits: 0 = 1 stop bit; 1 = 2 stop bits (1.5 when wls_in=0)
pen_in  input  1  parity enable
eps_in  input  1  even parity select
sp_in  input  1  stick parity
bc_in  input  1  break control; forces txd_out low
tx_en_in  input  1  transmitter enable (utrst); 0 aborts and holds idle
tx_valid_in  input  1  FIFO has a character
tx_data_in  input  8  character from FIFO
tx_ready_out  output  1  block accepts a character this cycle
txd_out  output  1  serial output, idle high
temt_out  output  1  transmitter empty (FSM in IDLE)
tx_done_out  output  1  one-cycle pulse at end of last stop bit
baud_tick_out  output  1  one-cycle pulse per sample tick

Behaviour:
- Reset (apb_rst_in=1 at posedge) and reset values:
  - FSM=IDLE; all counters and the shift register cleared.
  - txd_out=1, temt_out=1, tx_done_out=0, baud_tick_out=0.
  - tx_ready_out=0 while apb_rst_in=1.
- Ready/accept:
  - tx_ready_out = (FSM==IDLE) && tx_en_in && !apb_rst_in (combinational).
  - Accept on posedge with tx_valid_in && tx_ready_out.
- Config latching:
  - On accept, latch tx_data_in masked to 5+wls bits, and latch wls_in, stb_in, pen_in, eps_in, sp_in, dlr_in, osm_in.
  - Input changes mid-frame have no effect until the next accept.
- Timing:
  - Divisor counter runs 0..dlr-1; a sample tick fires when it reaches dlr-1.
  - A bit ends after OS sample ticks, so bit period = OS*dlr clocks.
  - Both counters restart at 0 on the accept edge.
  - baud_tick_out pulses on each sample tick only while the FSM is not in IDLE.
- FSM states:
  - IDLE -> START on accept; txd_out goes 0 on that same edge.
  - START lasts 1 bit -> DATA.
  - DATA lasts 5+wls bits, LSB first -> PARITY if pen, else STOP1.
  - PARITY lasts 1 bit -> STOP1.
  - STOP1 lasts 1 bit -> STOP2 if stb, else IDLE.
  - STOP2 lasts 1 bit, or floor(OS/2) sample ticks when wls=0 -> IDLE.
- Frame end: tx_done_out pulses on the edge that enters IDLE. The earliest next accept is in that IDLE cycle, giving a minimum 1-clock idle-high gap between frames.
- Parity, computed over the masked data bits:
  - sp=0, eps=1: parity bit = XOR of data bits (even parity).
  - sp=0, eps=0: parity bit = XNOR of data bits (odd parity).
  - sp=1: parity bit = ~eps.
- txd_out is registered: 0 in START, the current data bit in DATA, the parity bit in PARITY, 1 in STOP1/STOP2/IDLE.
- bc_in=1 forces txd_out=0 in every state. The FSM and handshake continue unaffected; on release, txd_out reverts to the FSM value next edge.
- tx_en_in=0: on the next edge, FSM->IDLE, counters cleared, txd_out=1. The frame in progress is discarded and tx_done_out is not pulsed.
- Latched dlr=0: no sample ticks are generated. The FSM stalls in its current state with txd_out held; tx_en_in=0 or reset recovers.
- Simultaneous events: reset has priority over tx_en_in; tx_en_in=0 has priority over accept and over bit advance.

Test Plan:
- dlr=1, osm=0, wls=3, pen=0, stb=0, send 0x55 -> txd_out = 0,1,0,1,0,1,0,1,0,1 with each bit 16 clocks; tx_done_out pulses 160 clocks after the accept edge; temt_out=0 for that interval.
- dlr=1, wls=0, pen=1, data 0x1F: eps=0, sp=0 -> parity bit 0; eps=1 -> parity 1; sp=1, eps=1 -> parity 0; each frame is 8 bits = 128 clocks.
- dlr=2, osm=0, wls=0, stb=1 -> stop time 32+16 = 48 clocks. Then osm=1, dlr=3, wls=3, stb=1 -> every bit 39 clocks; the two stop bits total 78 clocks.
- tx_valid_in held high with two characters, dlr=1 -> second accept exactly 1 clock after the first tx_done_out; txd_out is high for exactly 1 clock between frames.
- Mid-frame tx_en_in=0 during DATA -> txd_out=1 and temt_out=1 next edge, no tx_done_out. Re-enable -> next character transmits correctly from START.
- bc_in pulsed high for 50 clocks during STOP1 -> txd_out=0 throughout the pulse, frame timing and tx_done_out unchanged. Latched dlr=0 -> FSM holds state indefinitely with baud_tick_out=0.
